// File: rtl/inst_encoder_pkg.sv
// Shared encoder definitions: format codes, RV32I opcodes, FIFO word layout,
// field-placement and immediate-range helpers.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHIFT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } enc_word_t;

  // Code 3'd7 is undefined and falls through to the R layout.
  function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    case (fmt_e'(fmt))
      FMT_I:     w = {imm[11:0], rs1, f3, rd, op};
      FMT_SHIFT: w = {f7, imm[4:0], rs1, f3, rd, op};
      FMT_S:     w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:     w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:     w = {imm[31:12], rd, op};
      FMT_J:     w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:   w = {f7, rs2, rs1, f3, rd, op};
    endcase
    return w;
  endfunction

  function automatic logic imm_legal(input logic [2:0] fmt, input logic [31:0] imm);
    logic ok;
    case (fmt_e'(fmt))
      FMT_R:         ok = 1'b1;
      FMT_I, FMT_S:  ok = (&imm[31:11]) || !(|imm[31:11]);
      FMT_SHIFT:     ok = !(|imm[31:5]);
      FMT_B:         ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
      FMT_U:         ok = !(|imm[11:0]);
      FMT_J:         ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous FIFO holding encoded {addr, inst} words.
module enc_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I field-set to instruction-word encoder with address tagging and a
// 2-deep output FIFO. Define ENC_RANGE_CHECK_EN to drop illegal immediates.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err
);

  enc_word_t   wdata, rdata;
  logic [31:0] addr_q, addr_d;
  logic        full, empty, accept, legal, push, pop;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wdata      = '0;
    wdata.inst = encode(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
    wdata.addr = addr_q;
    addr_d     = push ? addr_q + 32'd4 : addr_q;
  end

  // Addresses are assigned at push; FIFO order makes this equal to advancing per output handshake.
  assign out_inst = out_valid ? rdata.inst : '0;
  assign out_addr = out_valid ? rdata.addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= BASE_ADDR;
    else        addr_q <= addr_d;
  end

`ifdef ENC_RANGE_CHECK_EN
  logic err_q;

  assign legal = imm_legal(in_fmt, in_imm);
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (accept && !legal) err_q <= 1'b1;
  end
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  enc_fifo #(
    .WIDTH($bits(enc_word_t)),
    .DEPTH(2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the address tagged on the first emitted word after reset.
REQ-002 SHALL use a single clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  the field set on the in_* ports is valid.
REQ-006 in_ready  output  1  encoder accepts the field set this cycle.
REQ-007 in_fmt  input  3  format code: R, I, SHIFT, S, B, U or J.
REQ-008 in_opcode  input  7  RV32I opcode, placed in inst[6:0].
REQ-009 in_funct3  input  3  funct3 field.
REQ-010 in_funct7  input  7  funct7 field, used by R and SHIFT only.
REQ-011 in_rd, in_rs1, in_rs2  input  5 each  register addresses.
REQ-012 in_imm  input  32  full immediate value, in the same form the decoder produces.
REQ-013 out_valid  output  1  out_inst and out_addr are valid.
REQ-014 out_ready  input  1  the consumer (instruction-memory loader) accepts the word.
REQ-015 out_inst  output  32  encoded instruction.
REQ-016 out_addr  output  32  instruction-memory byte address of out_inst.
REQ-017 err  output  1  sticky immediate-range error flag.

Function
REQ-018 Input handshake SHALL complete when in_valid && in_ready; output handshake SHALL complete when out_valid && out_ready.
REQ-019 Encoding is registered: a word accepted at edge N SHALL make out_valid high after edge N, i.e. one-cycle latency.
REQ-020 Words SHALL be held in a 2-entry FIFO; in_ready = !full, independent of out_ready.
REQ-021 Push and pop in the same cycle when not full SHALL keep the FIFO occupancy unchanged and preserve order.
REQ-022 When empty, out_valid SHALL be 0; out_inst and out_addr SHALL be held stable while out_valid && !out_ready.
REQ-023 out_addr SHALL start at BASE_ADDR, increment by 4 on each output handshake, and wrap modulo 2^32.
REQ-024 Field placement SHALL follow RV32I:
- R: {funct7, rs2, rs1, funct3, rd, op}.
- I: {imm[11:0], rs1, funct3, rd, op}.
- SHIFT: {funct7, imm[4:0], rs1, funct3, rd, op}.
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- U: {imm[31:12], rd, op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-025 An undefined in_fmt SHALL be treated as a range error (see Configuration).

Reset
REQ-026 On rst_n low, asynchronously: FIFO empty, out_valid=0, out_inst=0, out_addr=BASE_ADDR, err=0, in_ready=1.
REQ-027 Reset mid-operation SHALL discard all buffered words without emitting them.

Configuration
REQ-028 Range checking SHALL be compiled in only when macro ENC_RANGE_CHECK_EN is defined.
REQ-029 With the macro, a word SHALL be illegal when any of the following holds:
- I/S: imm is not 12-bit sign-extended.
- B: imm is not 13-bit sign-extended, or imm[0]=1.
- J: imm is not 21-bit sign-extended, or imm[0]=1.
- U: imm[11:0]!=0.
- SHIFT: imm>31.
- in_fmt is undefined.
REQ-030 With the macro, an illegal word SHALL still handshake, SHALL NOT be pushed, and SHALL NOT advance out_addr; err SHALL set from the next edge and hold until reset.
REQ-031 Without the macro, fields SHALL be truncated silently, undefined formats SHALL encode as R, and err SHALL be tied 0.

Structure
REQ-032 Format codes and opcode constants SHALL live in the shared definitions file alongside the decoder's opcode macros.
REQ-033 The FIFO SHALL be a sub-module named enc_fifo, parameterised by width (64: inst+addr) and depth 2.

Verification
REQ-034 I-type: fmt=I, op=0x13, rd=1, rs1=0, imm=5 -> out_inst=0x00500093, out_addr=BASE_ADDR, one cycle after accept.
REQ-035 R-type back-to-back with out_ready=1: rd=3, rs1=1, rs2=2, funct7=0 then 0x20 -> 0x002081B3 then 0x402081B3; addresses +0, +4; no stall.
REQ-036 S/U/J: sw x2,8(x1) -> 0x0020A423; lui x5 imm=0x12345000 -> 0x123452B7; jal x1 imm=8 -> 0x008000EF.
REQ-037 Backpressure: push 2 words, out_ready=0 for 3 cycles -> in_ready=0, out_inst stable; on release, both words drain in order.
REQ-038 With ENC_RANGE_CHECK_EN, fmt=B, imm=5 -> word dropped, err=1 after next edge, next legal word takes the unadvanced address.
REQ-039 Assert rst_n low with 2 words buffered -> out_valid=0 immediately; first post-reset word gets out_addr=BASE_ADDR.
